// File: rtl/taillight_decoder.sv
// ---------------------------------------------------------------------------
// taillight_decoder
//
// Receiving-side monitor for the six-lamp tail-light interface. On every
// sample_en strobe both lamp triplets are decoded back to a sweep step
// (0..3), the step sequence is validated, completed sweeps (3 -> 0) are
// counted and illegal patterns / transitions are reported through a sticky
// error flag plus a cause code.
//
// Optional build feature (macro TLDEC_STALL_CHECK_EN):
//   when defined, a per-side hold counter flags a nonzero step that repeats
//   for more than HOLD_MAX consecutive samples (error code 11).
//
// Parameters
//   CNT_W     width of each saturating completed-sweep counter
//   HOLD_MAX  longest allowed run of repeated nonzero steps (stall check only)
//
// Ports
//   clk                          system clock
//   reset                        asynchronous, active-high reset
//   sample_en                    lamp lines valid, sample them this edge
//   LA, LB, LC / RA, RB, RC      left / right lamps, A lights first
//   clear_err                    synchronous clear of both sticky errors
//   left_step,  right_step       decoded step of the last accepted sample
//   left_active, right_active    decoded step is nonzero
//   left_done,  right_done       one-cycle pulse on a completed sweep
//   left_count, right_count      completed sweeps, saturating
//   left_err,   right_err        sticky error flags
//   left_err_code, right_err_code  01 pattern, 10 transition, 11 stall
// ---------------------------------------------------------------------------
module taillight_decoder #(
  parameter int CNT_W    = 8,
  parameter int HOLD_MAX = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic             LA,
  input  logic             LB,
  input  logic             LC,
  input  logic             RA,
  input  logic             RB,
  input  logic             RC,
  input  logic             clear_err,
  output logic [1:0]       left_step,
  output logic [1:0]       right_step,
  output logic             left_active,
  output logic             right_active,
  output logic             left_done,
  output logic             right_done,
  output logic [CNT_W-1:0] left_count,
  output logic [CNT_W-1:0] right_count,
  output logic             left_err,
  output logic             right_err,
  output logic [1:0]       left_err_code,
  output logic [1:0]       right_err_code
);

  localparam logic [1:0] ERR_PATTERN = 2'b01;
  localparam logic [1:0] ERR_TRANS   = 2'b10;
  localparam logic [1:0] ERR_STALL   = 2'b11;

  // Returns {valid, step}; thermometer codes are the only legal patterns.
  function automatic logic [2:0] f_decode(input logic [2:0] code);
    logic [2:0] res;
    case (code)
      3'b000:  res = 3'b1_00;
      3'b001:  res = 3'b1_01;
      3'b011:  res = 3'b1_10;
      3'b111:  res = 3'b1_11;
      default: res = 3'b0_00;
    endcase
    return res;
  endfunction

  // Hold, advance by one, or wrap 3 -> 0 (the 2-bit increment wraps for us).
  function automatic logic f_legal_trans(input logic [1:0] p, input logic [1:0] n);
    return (n == p) || (n == 2'(p + 2'd1));
  endfunction

  // Index 0 = left side, index 1 = right side.
  logic [2:0]       w_code     [2];
  logic [2:0]       w_dec      [2];
  logic             w_legal    [2];
  logic             w_stall    [2];

  logic             r_first;
  logic             w_first_nx;
  logic [1:0]       r_step     [2];
  logic [1:0]       w_step_nx  [2];
  logic [CNT_W-1:0] r_count    [2];
  logic [CNT_W-1:0] w_count_nx [2];
  logic             r_done     [2];
  logic             w_done_nx  [2];
  logic             r_err      [2];
  logic             w_err_nx   [2];
  logic [1:0]       r_ecode    [2];
  logic [1:0]       w_ecode_nx [2];

`ifdef TLDEC_STALL_CHECK_EN
  localparam int HOLD_W = $clog2(HOLD_MAX + 2);
  logic [HOLD_W-1:0] r_hold    [2];
  logic [HOLD_W-1:0] w_hold_nx [2];
`endif

  assign w_code[0] = {LC, LB, LA};
  assign w_code[1] = {RC, RB, RA};

  always_comb begin
    w_first_nx = r_first;
    if (sample_en) w_first_nx = 1'b0;

    for (int s = 0; s < 2; s++) begin
      w_dec[s]   = f_decode(w_code[s]);
      w_legal[s] = f_legal_trans(r_step[s], w_dec[s][1:0]);
`ifdef TLDEC_STALL_CHECK_EN
      w_stall[s] = (w_dec[s][1:0] == r_step[s]) && (r_step[s] != 2'd0) &&
                   ((int'(r_hold[s]) + 1) > HOLD_MAX);
      w_hold_nx[s] = r_hold[s];
`else
      // HOLD_MAX only has meaning when the stall check is built in.
      w_stall[s] = (HOLD_MAX < 0);
`endif
      w_step_nx[s]  = r_step[s];
      w_count_nx[s] = r_count[s];
      w_done_nx[s]  = 1'b0;
      w_err_nx[s]   = r_err[s];
      w_ecode_nx[s] = r_ecode[s];

      // Clear first; an error found on the same edge overrides it below.
      if (clear_err) begin
        w_err_nx[s]   = 1'b0;
        w_ecode_nx[s] = 2'b00;
      end

      if (sample_en) begin
        if (!w_dec[s][2]) begin
          w_err_nx[s]   = 1'b1;
          w_ecode_nx[s] = ERR_PATTERN;
          w_step_nx[s]  = 2'd0;
`ifdef TLDEC_STALL_CHECK_EN
          w_hold_nx[s]  = '0;
`endif
        end else if (r_first) begin
          // Nothing to compare against yet: accept any legal step.
          w_step_nx[s]  = w_dec[s][1:0];
`ifdef TLDEC_STALL_CHECK_EN
          w_hold_nx[s]  = '0;
`endif
        end else if (!w_legal[s]) begin
          w_err_nx[s]   = 1'b1;
          w_ecode_nx[s] = ERR_TRANS;
          w_step_nx[s]  = w_dec[s][1:0];
`ifdef TLDEC_STALL_CHECK_EN
          w_hold_nx[s]  = '0;
`endif
        end else if (w_stall[s]) begin
          w_err_nx[s]   = 1'b1;
          w_ecode_nx[s] = ERR_STALL;
          w_step_nx[s]  = w_dec[s][1:0];
`ifdef TLDEC_STALL_CHECK_EN
          w_hold_nx[s]  = '0;
`endif
        end else begin
          w_step_nx[s] = w_dec[s][1:0];
          if (r_step[s] == 2'd3 && w_dec[s][1:0] == 2'd0) begin
            w_done_nx[s] = 1'b1;
            if (r_count[s] != {CNT_W{1'b1}}) w_count_nx[s] = r_count[s] + 1'b1;
          end
`ifdef TLDEC_STALL_CHECK_EN
          // Only repeats of a lit step accumulate; any change restarts the run.
          if (w_dec[s][1:0] == r_step[s] && r_step[s] != 2'd0)
            w_hold_nx[s] = r_hold[s] + 1'b1;
          else
            w_hold_nx[s] = '0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_first <= 1'b1;
      for (int s = 0; s < 2; s++) begin
        r_step[s]  <= 2'd0;
        r_count[s] <= '0;
        r_done[s]  <= 1'b0;
        r_err[s]   <= 1'b0;
        r_ecode[s] <= 2'b00;
`ifdef TLDEC_STALL_CHECK_EN
        r_hold[s]  <= '0;
`endif
      end
    end else begin
      r_first <= w_first_nx;
      for (int s = 0; s < 2; s++) begin
        r_step[s]  <= w_step_nx[s];
        r_count[s] <= w_count_nx[s];
        r_done[s]  <= w_done_nx[s];
        r_err[s]   <= w_err_nx[s];
        r_ecode[s] <= w_ecode_nx[s];
`ifdef TLDEC_STALL_CHECK_EN
        r_hold[s]  <= w_hold_nx[s];
`endif
      end
    end
  end

  assign left_step      = r_step[0];
  assign right_step     = r_step[1];
  assign left_active    = (r_step[0] != 2'd0);
  assign right_active   = (r_step[1] != 2'd0);
  assign left_done      = r_done[0];
  assign right_done     = r_done[1];
  assign left_count     = r_count[0];
  assign right_count    = r_count[1];
  assign left_err       = r_err[0];
  assign right_err      = r_err[1];
  assign left_err_code  = r_ecode[0];
  assign right_err_code = r_ecode[1];

endmodule
